// File: rtl/axis_rr_packet_arbiter.sv
// N-to-1 AXI4-Stream arbiter: round-robin grants held for a whole packet,
// with a single registered output stage shared by all upstream ports.
module axis_rr_packet_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int DEST_WIDTH = 4,
    parameter int USER_WIDTH = 1,
    localparam int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
    localparam int KEEP_W    = DATA_WIDTH / 8
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic [NUM_PORTS-1:0]             s_tvalid,
    output logic [NUM_PORTS-1:0]             s_tready,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_tdata,
    input  logic [NUM_PORTS*KEEP_W-1:0]      s_tkeep,
    input  logic [NUM_PORTS-1:0]             s_tlast,
    input  logic [NUM_PORTS*ID_WIDTH-1:0]    s_tid,
    input  logic [NUM_PORTS*DEST_WIDTH-1:0]  s_tdest,
    input  logic [NUM_PORTS*USER_WIDTH-1:0]  s_tuser,
    output logic                             m_tvalid,
    input  logic                             m_tready,
    output logic [DATA_WIDTH-1:0]            m_tdata,
    output logic [KEEP_W-1:0]                m_tkeep,
    output logic                             m_tlast,
    output logic [ID_WIDTH-1:0]              m_tid,
    output logic [DEST_WIDTH-1:0]            m_tdest,
    output logic [USER_WIDTH-1:0]            m_tuser,
    output logic                             grant_valid,
    output logic [IDX_W-1:0]                 grant_idx
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BUSY = 1'b1;
    localparam logic [IDX_W-1:0] LAST_PORT = IDX_W'(NUM_PORTS - 1);

    logic             state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] last_grant_q, last_grant_d;

    logic                  m_tvalid_q;
    logic [DATA_WIDTH-1:0] m_tdata_q;
    logic [KEEP_W-1:0]     m_tkeep_q;
    logic                  m_tlast_q;
    logic [ID_WIDTH-1:0]   m_tid_q;
    logic [DEST_WIDTH-1:0] m_tdest_q;
    logic [USER_WIDTH-1:0] m_tuser_q;

    logic             arb_found;
    logic [IDX_W-1:0] arb_idx;
    logic [IDX_W-1:0] cand;
    logic             out_ready;
    logic             accept;

    // Search starts just after the previous winner, so it gets lowest priority.
    // NOTE: every variable written in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = last_grant_q;
        cand      = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            cand = IDX_W'((int'(last_grant_q) + k) % NUM_PORTS);
            if (!arb_found && s_tvalid[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    // Ready depends only on the output register, never on s_tvalid.
    assign out_ready = !m_tvalid_q || m_tready;
    assign accept    = (state_q == ST_BUSY) && s_tvalid[grant_q] && out_ready;

    always_comb begin
        s_tready = '0;
        if (state_q == ST_BUSY) s_tready[grant_q] = out_ready;
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_found) begin
                    state_d      = ST_BUSY;
                    grant_d      = arb_idx;
                    last_grant_d = arb_idx;
                end
            end
            ST_BUSY: begin
                if (accept && s_tlast[grant_q]) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= LAST_PORT;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Payload registers are reset too so the output bus reads as zero after reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= '0;
            m_tkeep_q  <= '0;
            m_tlast_q  <= 1'b0;
            m_tid_q    <= '0;
            m_tdest_q  <= '0;
            m_tuser_q  <= '0;
        end else if (accept) begin
            m_tvalid_q <= 1'b1;
            m_tdata_q  <= s_tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
            m_tkeep_q  <= s_tkeep[int'(grant_q)*KEEP_W +: KEEP_W];
            m_tlast_q  <= s_tlast[grant_q];
            m_tid_q    <= s_tid[int'(grant_q)*ID_WIDTH +: ID_WIDTH];
            m_tdest_q  <= s_tdest[int'(grant_q)*DEST_WIDTH +: DEST_WIDTH];
            m_tuser_q  <= s_tuser[int'(grant_q)*USER_WIDTH +: USER_WIDTH];
        end else if (m_tready) begin
            m_tvalid_q <= 1'b0;
        end
    end

    assign m_tvalid    = m_tvalid_q;
    assign m_tdata     = m_tdata_q;
    assign m_tkeep     = m_tkeep_q;
    assign m_tlast     = m_tlast_q;
    assign m_tid       = m_tid_q;
    assign m_tdest     = m_tdest_q;
    assign m_tuser     = m_tuser_q;
    assign grant_valid = (state_q == ST_BUSY);
    assign grant_idx   = grant_q;

endmodule

// File: tb/tb_axis_rr_packet_arbiter.sv
// Self-checking bench for axis_rr_packet_arbiter: cycle vector table, fairness,
// randomized back-pressure against a packet-order model, and mid-packet reset.
module tb_axis_rr_packet_arbiter;

    localparam int NP  = 4;
    localparam int DW  = 32;
    localparam int KW  = DW / 8;
    localparam int IW  = 4;
    localparam int DSW = 4;
    localparam int UW  = 1;
    localparam int IXW = 2;

    typedef struct packed {
        logic [DW-1:0]  data;
        logic [KW-1:0]  keep;
        logic           last;
        logic [IW-1:0]  id;
        logic [DSW-1:0] dest;
        logic [UW-1:0]  user;
    } beat_t;

    typedef struct packed {
        logic [NP-1:0] tvalid;
        logic [7:0]    data;
        logic          last;
        logic          mready;
        logic [NP-1:0] exp_rdy;
        logic          exp_gv;
        logic [1:0]    exp_gi;
        logic          exp_mv;
        logic [7:0]    exp_md;
        logic          exp_ml;
    } vec_t;

    logic              aclk;
    logic              aresetn;
    logic [NP-1:0]     s_tvalid;
    logic [NP-1:0]     s_tready;
    logic [NP*DW-1:0]  s_tdata;
    logic [NP*KW-1:0]  s_tkeep;
    logic [NP-1:0]     s_tlast;
    logic [NP*IW-1:0]  s_tid;
    logic [NP*DSW-1:0] s_tdest;
    logic [NP*UW-1:0]  s_tuser;
    logic              m_tvalid;
    logic              m_tready;
    logic [DW-1:0]     m_tdata;
    logic [KW-1:0]     m_tkeep;
    logic              m_tlast;
    logic [IW-1:0]     m_tid;
    logic [DSW-1:0]    m_tdest;
    logic [UW-1:0]     m_tuser;
    logic              grant_valid;
    logic [IXW-1:0]    grant_idx;

    int n_cmp = 0;
    int n_err = 0;

    beat_t src_q [NP][$];
    beat_t exp_q [$];
    int    exp_grant_q [$];
    int    grant_log [$];
    int    cycle_log [$];
    vec_t  vecs [19];

    axis_rr_packet_arbiter #(
        .NUM_PORTS(NP), .DATA_WIDTH(DW), .ID_WIDTH(IW), .DEST_WIDTH(DSW), .USER_WIDTH(UW)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tkeep(s_tkeep),
        .s_tlast(s_tlast), .s_tid(s_tid), .s_tdest(s_tdest), .s_tuser(s_tuser),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
        .m_tlast(m_tlast), .m_tid(m_tid), .m_tdest(m_tdest), .m_tuser(m_tuser),
        .grant_valid(grant_valid), .grant_idx(grant_idx)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic put_beat(input int p, input beat_t b);
        s_tdata[p*DW +: DW]   = b.data;
        s_tkeep[p*KW +: KW]   = b.keep;
        s_tlast[p]            = b.last;
        s_tid[p*IW +: IW]     = b.id;
        s_tdest[p*DSW +: DSW] = b.dest;
        s_tuser[p*UW +: UW]   = b.user;
    endtask

    function automatic beat_t out_beat();
        return beat_t'({m_tdata, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser});
    endfunction

    task automatic drive_idle();
        s_tvalid = '0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tlast  = '0;
        s_tid    = '0;
        s_tdest  = '0;
        s_tuser  = '0;
        m_tready = 1'b1;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        drive_idle();
        repeat (3) @(posedge aclk);
        #1 aresetn = 1'b1;
    endtask

    // Reference: packets leave in round-robin order over ports that still hold packets,
    // starting after port NP-1, each packet whole. Valid is held while a port has data.
    task automatic build_model();
        beat_t tmp [NP][$];
        int    last = NP - 1;
        int    p;
        bit    found;
        beat_t b;
        exp_q.delete();
        exp_grant_q.delete();
        for (int i = 0; i < NP; i++) tmp[i] = src_q[i];
        forever begin
            found = 1'b0;
            p = 0;
            for (int k = 1; k <= NP; k++) begin
                if (!found && tmp[(last + k) % NP].size() > 0) begin
                    found = 1'b1;
                    p = (last + k) % NP;
                end
            end
            if (!found) break;
            exp_grant_q.push_back(p);
            do begin
                b = tmp[p].pop_front();
                exp_q.push_back(b);
            end while (!b.last);
            last = p;
        end
    endtask

    task automatic run_traffic(input bit rand_ready, input int budget);
        int    cyc = 0;
        bit    in_pkt = 1'b0;
        bit    hold_chk = 1'b0;
        beat_t held = '0;
        beat_t e;
        logic [NP-1:0] hs;
        int    p;
        grant_log.delete();
        cycle_log.delete();
        build_model();
        while (exp_q.size() > 0 && cyc < budget) begin
            @(posedge aclk); #1;
            for (int i = 0; i < NP; i++) begin
                if (src_q[i].size() > 0) begin
                    s_tvalid[i] = 1'b1;
                    put_beat(i, src_q[i][0]);
                end else begin
                    s_tvalid[i] = 1'b0;
                end
            end
            m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            #3;
            if (hold_chk) check("stall_hold", {m_tvalid, out_beat()}, {1'b1, held});
            hold_chk = m_tvalid && !m_tready;
            held = out_beat();
            if (m_tvalid && !m_tready) check("bp_sready", 64'(s_tready), 64'd0);
            if (m_tvalid && m_tready) begin
                e = exp_q.pop_front();
                check("out_beat", out_beat(), e);
            end
            hs = s_tvalid & s_tready;
            if (hs != '0) begin
                check("hs_onehot", 64'($onehot(hs)), 64'd1);
                p = 0;
                for (int i = NP - 1; i >= 0; i--) if (hs[i]) p = i;
                if (!in_pkt) begin
                    grant_log.push_back(p);
                    cycle_log.push_back(cyc);
                    if (exp_grant_q.size() > 0) check("grant_order", p, exp_grant_q.pop_front());
                    else check("extra_grant", p, 64'hFFFF);
                    check("grant_idx", {grant_valid, grant_idx}, {1'b1, 2'(p)});
                end
                in_pkt = !src_q[p][0].last;
                void'(src_q[p].pop_front());
            end
            cyc++;
        end
        if (exp_q.size() != 0) check("traffic_timeout", exp_q.size(), 0);
        @(posedge aclk); #1;
        drive_idle();
        #3;
        check("drained", m_tvalid, 0);
    endtask

    initial begin
        beat_t b;
        beat_t pk [8];
        int    acc;
        int    guard;
        int    exp_order [8];

        aresetn = 1'b0;
        drive_idle();

        // Reset held with every port requesting.
        for (int c = 0; c < 90; c++) begin
            @(posedge aclk); #1;
            s_tvalid = '1;
            s_tdata  = {$urandom, $urandom, $urandom, $urandom};
            s_tlast  = 4'($urandom);
            s_tid    = 16'($urandom);
            #3;
            check("reset_hold",
                  {m_tvalid, m_tlast, m_tdata, m_tkeep, m_tid, m_tdest, m_tuser,
                   s_tready, grant_valid, grant_idx}, 64'd0);
        end
        @(posedge aclk); #1;
        drive_idle();
        aresetn = 1'b1;

        // Cycle table: port 2 packet, port 0 single beat under stall, port 3 with back-pressure.
        vecs[0]  = '{4'b0100, 8'h11, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0};
        vecs[1]  = '{4'b0100, 8'h11, 1'b0, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0, 8'h00, 1'b0};
        vecs[2]  = '{4'b0100, 8'h22, 1'b0, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1, 8'h11, 1'b0};
        vecs[3]  = '{4'b0100, 8'h33, 1'b0, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1, 8'h22, 1'b0};
        vecs[4]  = '{4'b0100, 8'h44, 1'b1, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1, 8'h33, 1'b0};
        vecs[5]  = '{4'b0000, 8'h00, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b1, 8'h44, 1'b1};
        vecs[6]  = '{4'b0000, 8'h00, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b0, 8'h00, 1'b0};
        vecs[7]  = '{4'b0001, 8'hAA, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b0, 8'h00, 1'b0};
        vecs[8]  = '{4'b0001, 8'hAA, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0, 8'h00, 1'b0};
        vecs[9]  = '{4'b0000, 8'h00, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b1, 8'hAA, 1'b1};
        vecs[10] = '{4'b0000, 8'h00, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b1, 8'hAA, 1'b1};
        vecs[11] = '{4'b0000, 8'h00, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1, 8'hAA, 1'b1};
        vecs[12] = '{4'b0000, 8'h00, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0};
        vecs[13] = '{4'b1000, 8'hBB, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0};
        vecs[14] = '{4'b1000, 8'hBB, 1'b0, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b0, 8'h00, 1'b0};
        vecs[15] = '{4'b1000, 8'hCC, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd3, 1'b1, 8'hBB, 1'b0};
        vecs[16] = '{4'b1000, 8'hCC, 1'b1, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1, 8'hBB, 1'b0};
        vecs[17] = '{4'b0000, 8'h00, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b1, 8'hCC, 1'b1};
        vecs[18] = '{4'b0000, 8'h00, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b0, 8'h00, 1'b0};

        for (int i = 0; i < 19; i++) begin
            @(posedge aclk); #1;
            s_tvalid = vecs[i].tvalid;
            b = '0;
            b.data = {24'h0, vecs[i].data};
            b.keep = '1;
            b.last = vecs[i].last;
            b.id   = 4'd5;
            for (int p = 0; p < NP; p++) put_beat(p, b);
            m_tready = vecs[i].mready;
            #3;
            check($sformatf("vec%0d", i),
                  {s_tready, grant_valid, grant_idx, m_tvalid,
                   m_tvalid ? {m_tdata, m_tlast, m_tid} : 37'd0},
                  {vecs[i].exp_rdy, vecs[i].exp_gv, vecs[i].exp_gi, vecs[i].exp_mv,
                   vecs[i].exp_mv ? {24'h0, vecs[i].exp_md, vecs[i].exp_ml, 4'd5} : 37'd0});
        end

        // Fairness: every port keeps offering 2-beat packets.
        do_reset();
        for (int p = 0; p < NP; p++)
            for (int k = 0; k < 2; k++)
                for (int j = 0; j < 2; j++) begin
                    b = '0;
                    b.data = {8'(p), 8'(k), 8'(j), 8'h5A};
                    b.keep = 4'hF;
                    b.last = (j == 1);
                    b.id   = 4'(p);
                    b.dest = 4'(k);
                    src_q[p].push_back(b);
                end
        run_traffic(1'b0, 200);
        exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
        check("rr_count", grant_log.size(), 8);
        if (grant_log.size() == 8) begin
            for (int i = 0; i < 8; i++) check($sformatf("rr_order%0d", i), grant_log[i], exp_order[i]);
            for (int i = 1; i < 8; i++) check($sformatf("rr_gap%0d", i), cycle_log[i] - cycle_log[i-1], 3);
        end

        // Random back-pressure over 100 packets of 1..16 beats.
        do_reset();
        for (int n = 0; n < 100; n++) begin
            int p;
            int len;
            p   = $urandom_range(0, NP - 1);
            len = $urandom_range(1, 16);
            for (int j = 0; j < len; j++) begin
                b.data = $urandom;
                b.keep = 4'($urandom);
                b.last = (j == len - 1);
                b.id   = 4'($urandom);
                b.dest = 4'($urandom);
                b.user = 1'($urandom);
                src_q[p].push_back(b);
            end
        end
        run_traffic(1'b1, 20000);

        // Reset in the middle of an 8-beat packet from port 1.
        do_reset();
        for (int j = 0; j < 8; j++) begin
            pk[j] = '0;
            pk[j].data = 32'hC0DE_0000 + 32'(j);
            pk[j].keep = 4'hF;
            pk[j].last = (j == 7);
        end
        acc = 0;
        guard = 0;
        while (acc < 3 && guard < 40) begin
            @(posedge aclk); #1;
            s_tvalid = 4'b0010;
            put_beat(1, pk[acc]);
            m_tready = 1'b1;
            #3;
            if (s_tvalid[1] && s_tready[1]) acc++;
            guard++;
        end
        check("mid_rst_progress", acc, 3);
        @(posedge aclk); #1;
        s_tvalid = 4'b0011;
        put_beat(1, pk[3]);
        put_beat(0, pk[0]);
        check("pre_rst_mvalid", m_tvalid, 1);
        aresetn = 1'b0;
        #1;
        check("rst_async", {m_tvalid, grant_valid, s_tready, m_tdata}, 64'd0);
        repeat (3) @(posedge aclk);
        #1 aresetn = 1'b1;
        #3;
        check("post_rst_idle", {grant_valid, m_tvalid}, 64'd0);
        @(posedge aclk); #4;
        check("post_rst_grant", {grant_valid, grant_idx, s_tready}, {1'b1, 2'd0, 4'b0001});
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
